// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_shift_tx serial transmitter.
// PISO_PARITY_EN adds one even-parity bit per frame.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_DEF = 8;

  // Bits on the wire per accepted word.
  function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter that tracks the remaining bits of a frame.
// Latency 1 cycle from load/enable to count; zero flags the last-bit cycle.
module piso_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          load,
  input  logic          enable,
  input  logic [CW-1:0] init,
  output logic [CW-1:0] count,
  output logic          zero
);

  assign zero = (count == '0);

  // Holds at zero so an idle transmitter never wraps the count.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= init;
    end else if (enable && !zero) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter, MSB first; first bit one cycle after accept.
// Ready only when idle or on the last bit, so back-to-back words stream gap-free; PISO_PARITY_EN appends even parity.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] PI,
  input  logic             Load,
  output logic             Ready,
  output logic             SO,
  output logic             SOValid,
  output logic             Done
);

  localparam int              FRAME    = frame_len(WIDTH);
  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_IDX = CW'(FRAME - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt_unused;
  logic             zero;
  logic             last;
  logic             accept;

  assign last    = (state == SHIFT) && zero;
  assign Ready   = (state == IDLE) || last;
  assign accept  = Load && Ready;
  assign SOValid = (state == SHIFT);
  assign Done    = last;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .Clock  (Clock),
    .Reset  (Reset),
    .load   (accept),
    .enable (state == SHIFT),
    .init   (LAST_IDX),
    .count  (cnt_unused),
    .zero   (zero)
  );

`ifdef PISO_PARITY_EN
  logic parity;

  // Parity rides in the counter-zero slot after the data bits.
  assign SO = SOValid && (zero ? parity : shreg[WIDTH-1]);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= ^PI;
    end
  end
`else
  assign SO = SOValid && shreg[WIDTH-1];
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      shreg <= '0;
    end else if (accept) begin
      state <= SHIFT;
      shreg <= PI;
    end else if (state == SHIFT) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
      if (zero) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: doc/piso_shift_tx.md
# piso_shift_tx

Parallel-in, serial-out transmitter: the transmit end of the single-bit serial link that the SI/PO shift register receives. Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out MSB first, one bit per Clock. A qualifying strobe accompanies each bit, and a completion pulse marks the end of each word. Back-to-back words stream without idle gaps, so a downstream SIPO sees a continuous bit train.

## Interface
- WIDTH, 8, data word width in bits (≥2)
- Clock  input  1  system clock, all state on posedge
- Reset  input  1  synchronous, active-high reset
- PI  input  WIDTH  parallel word, sampled only on an accepted load
- Load  input  1  load request (valid)
- Ready  output  1  transmitter can accept a word this cycle
- SO  output  1  serial data out, MSB first
- SOValid  output  1  SO carries a frame bit this cycle
- Done  output  1  one-cycle pulse coincident with the last bit of a frame

## Operation
- Reset values: SO=0, SOValid=0, Done=0, Ready=1; state IDLE; shift register and bit counter cleared.
- FSM states: IDLE and SHIFT.
- Acceptance: a word is accepted at a posedge where Load=1 and Ready=1. PI is captured into the shift register and the counter is set to FRAME-1, where FRAME=WIDTH (or WIDTH+1 with parity).
- SHIFT:
  - SO = shift-register MSB and SOValid=1.
  - Each posedge shifts left by one, fills the LSB with 0, and decrements the counter.
- Last bit: the cycle in which the counter is 0.
  - Done=1 and Ready=1.
  - If Load=1 in this cycle, the next word is captured and SHIFT continues with no gap.
  - Otherwise the FSM returns to IDLE.
- Ready = (state==IDLE) || last-bit cycle. It is a function of registered state only; there is no combinational path from Load.
- Load while busy and not in the last-bit cycle: ignored, PI not sampled, no error flag.
- IDLE: SO=0, SOValid=0, Done=0.
- Reset asserted mid-frame: the frame is aborted at that posedge and all outputs take reset values the next cycle. No partial Done is issued.

## Timing
- Latency: accept at edge N → first bit (PI[WIDTH-1]) valid in cycle N+1 → last data bit in cycle N+WIDTH.
- Frame length: exactly FRAME cycles of SOValid=1 per accepted word.
- Continuous streaming: k back-to-back words produce k·FRAME consecutive SOValid cycles.
- Done is high in exactly one cycle per frame, aligned with SOValid.
- All outputs are registered or decoded from registers; none depends combinationally on PI or Load.

## Configuration
- PISO_PARITY_EN defined:
  - After the WIDTH data bits, one extra bit is sent: even parity, ^PI of the captured word.
  - FRAME=WIDTH+1. Done and Ready move to the parity-bit cycle.
- Undefined:
  - FRAME=WIDTH and no parity logic or parity register is present.

## Structure
- Shared package piso_pkg:
  - state enum typedef (IDLE, SHIFT)
  - default WIDTH constant
  - a function returning FRAME for a given WIDTH, used by RTL and bench under the same macro
- Sub-module piso_bit_counter:
  - loadable down-counter, width $clog2(WIDTH+1)
  - load and enable inputs; outputs the count and a zero flag (last-bit indicator)
- Top level holds the FSM, shift register, and parity register.

## Test plan
- Reset then idle 5 cycles → SO=0, SOValid=0, Done=0, Ready=1 throughout.
- WIDTH=8, load 8'hA5 once → SO = 1,0,1,0,0,1,0,1 in cycles 1–8; Done only in cycle 8; Ready low in cycles 1–7.
- Load 8'hB3, then 8'h0F in its last-bit cycle → 16 consecutive SOValid cycles: 10110011 then 00001111; two Done pulses at cycles 8 and 16.
- Load=1 held with PI=8'hFF during cycles 2–7 of an 8'h3C frame → 8'h3C is sent intact and the new word is taken only at the cycle-8 edge.
- Reset asserted in cycle 4 of an 8'hA5 frame → outputs take reset values the next cycle, no Done pulse; a following load of 8'h81 transmits cleanly.
- With PISO_PARITY_EN, load 8'hB3 (five 1s) → 9 bits, the 9th = 1, Done on bit 9; load 8'hA5 → 9th bit = 0.
